// File: rtl/idwt_synth_fir.sv
// idwt_synth_fir -- one-level inverse-DWT synthesis filter bank (polyphase).
//
// Takes one (a[m], d[m]) coefficient pair per input handshake and emits two
// reconstructed samples, y[2m] then y[2m+1]:
//   y[2m]   = g0_0*a[m] + g0_2*a[m-1] + g1_0*d[m] + g1_2*d[m-1]
//   y[2m+1] = g0_1*a[m] + g0_3*a[m-1] + g1_1*d[m] + g1_3*d[m-1]
// The upsampler's inserted zeros are never multiplied: each output phase
// uses only the two taps that land on real samples.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     coefficient pair handshake (a_in, d_in: W_IN signed)
//   g0_0..g0_3            lowpass synthesis taps (C_IN signed, quasi-static)
//   g1_0..g1_3            highpass synthesis taps (C_IN signed, quasi-static)
//   out_valid/out_ready   output handshake
//   y_out                 reconstructed sample (Y_OUT signed)
//   out_odd               0: y_out is y[2m], 1: y_out is y[2m+1]
//
// Build option: define IDWT_SAT_EN to clamp the sum into the Y_OUT range
// instead of wrapping, when Y_OUT is narrower than the accumulator.

// One output phase: two lowpass and two highpass products, full precision.
module idwt_phase_mac #(
  parameter int W_IN = 7,
  parameter int C_IN = 5,
  parameter int ACC_W = W_IN + C_IN + 2
) (
  input  logic signed [W_IN-1:0]  a_m,
  input  logic signed [W_IN-1:0]  a_m1,
  input  logic signed [W_IN-1:0]  d_m,
  input  logic signed [W_IN-1:0]  d_m1,
  input  logic signed [C_IN-1:0]  ga,
  input  logic signed [C_IN-1:0]  gb,
  input  logic signed [C_IN-1:0]  ha,
  input  logic signed [C_IN-1:0]  hb,
  output logic signed [ACC_W-1:0] sum
);
  localparam int P_W = W_IN + C_IN;

  logic signed [P_W-1:0] p0, p1, p2, p3;

  assign p0  = P_W'(a_m)  * P_W'(ga);
  assign p1  = P_W'(a_m1) * P_W'(gb);
  assign p2  = P_W'(d_m)  * P_W'(ha);
  assign p3  = P_W'(d_m1) * P_W'(hb);
  assign sum = ACC_W'(p0) + ACC_W'(p1) + ACC_W'(p2) + ACC_W'(p3);
endmodule

module idwt_synth_fir #(
  parameter int W_IN  = 7,
  parameter int C_IN  = 5,
  parameter int Y_OUT = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [W_IN-1:0]  a_in,
  input  logic signed [W_IN-1:0]  d_in,
  input  logic signed [C_IN-1:0]  g0_0,
  input  logic signed [C_IN-1:0]  g0_1,
  input  logic signed [C_IN-1:0]  g0_2,
  input  logic signed [C_IN-1:0]  g0_3,
  input  logic signed [C_IN-1:0]  g1_0,
  input  logic signed [C_IN-1:0]  g1_1,
  input  logic signed [C_IN-1:0]  g1_2,
  input  logic signed [C_IN-1:0]  g1_3,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [Y_OUT-1:0] y_out,
  output logic                    out_odd
);
  localparam int ACC_W  = W_IN + C_IN + 2;
  localparam int PHASES = 2;

  typedef enum logic [1:0] {S_IDLE, S_EVEN, S_ODD} state_t;

  state_t state, state_n;
  logic   ld_even, ld_odd;

  logic signed [W_IN-1:0] cur_a, cur_d, prev_a, prev_d;

  // Phase 0 (even) sees the incoming pair as a[m] and cur as a[m-1]; it is
  // evaluated in the same cycle the pair is accepted. Phase 1 (odd) runs
  // after the shift, so cur/prev already hold a[m]/a[m-1].
  logic [PHASES-1:0][W_IN-1:0]  ph_am, ph_am1, ph_dm, ph_dm1;
  logic [PHASES-1:0][C_IN-1:0]  ph_ga, ph_gb, ph_ha, ph_hb;
  logic [PHASES-1:0][ACC_W-1:0] ph_sum;
  logic [PHASES-1:0][Y_OUT-1:0] ph_fit;

  assign ph_am[0]  = a_in;   assign ph_am[1]  = cur_a;
  assign ph_am1[0] = cur_a;  assign ph_am1[1] = prev_a;
  assign ph_dm[0]  = d_in;   assign ph_dm[1]  = cur_d;
  assign ph_dm1[0] = cur_d;  assign ph_dm1[1] = prev_d;
  assign ph_ga[0]  = g0_0;   assign ph_ga[1]  = g0_1;
  assign ph_gb[0]  = g0_2;   assign ph_gb[1]  = g0_3;
  assign ph_ha[0]  = g1_0;   assign ph_ha[1]  = g1_1;
  assign ph_hb[0]  = g1_2;   assign ph_hb[1]  = g1_3;

  for (genvar p = 0; p < PHASES; p++) begin : g_phase
    idwt_phase_mac #(.W_IN(W_IN), .C_IN(C_IN), .ACC_W(ACC_W)) u_mac (
      .a_m  (ph_am[p]),
      .a_m1 (ph_am1[p]),
      .d_m  (ph_dm[p]),
      .d_m1 (ph_dm1[p]),
      .ga   (ph_ga[p]),
      .gb   (ph_gb[p]),
      .ha   (ph_ha[p]),
      .hb   (ph_hb[p]),
      .sum  (ph_sum[p])
    );

    if (Y_OUT >= ACC_W) begin : g_ext
      assign ph_fit[p] = Y_OUT'($signed(ph_sum[p]));
    end else begin : g_narrow
`ifdef IDWT_SAT_EN
      localparam logic signed [ACC_W-1:0] HI = ACC_W'((64'sd1 <<< (Y_OUT-1)) - 64'sd1);
      localparam logic signed [ACC_W-1:0] LO = ACC_W'(-(64'sd1 <<< (Y_OUT-1)));
      logic signed [Y_OUT-1:0] fit;
      always_comb begin
        fit = ph_sum[p][Y_OUT-1:0];
        if ($signed(ph_sum[p]) > HI)      fit = HI[Y_OUT-1:0];
        else if ($signed(ph_sum[p]) < LO) fit = LO[Y_OUT-1:0];
      end
      assign ph_fit[p] = fit;
`else
      assign ph_fit[p] = ph_sum[p][Y_OUT-1:0];
`endif
    end
  end

  // In S_ODD the next pair is taken in the same cycle the odd sample
  // leaves, so a continuous stream runs at one output per cycle.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    ld_even   = 1'b0;
    ld_odd    = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ld_even = 1'b1;
          state_n = S_EVEN;
        end
      end
      S_EVEN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          ld_odd  = 1'b1;
          state_n = S_ODD;
        end
      end
      S_ODD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            ld_even = 1'b1;
            state_n = S_EVEN;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      y_out   <= '0;
      out_odd <= 1'b0;
      cur_a   <= '0;
      cur_d   <= '0;
      prev_a  <= '0;
      prev_d  <= '0;
    end else begin
      state <= state_n;
      if (ld_even) begin
        y_out   <= ph_fit[0];
        out_odd <= 1'b0;
        prev_a  <= cur_a;
        prev_d  <= cur_d;
        cur_a   <= a_in;
        cur_d   <= d_in;
      end else if (ld_odd) begin
        y_out   <= ph_fit[1];
        out_odd <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_idwt_synth_fir.sv
// Directed bench for idwt_synth_fir: a default-width instance (Y_OUT=20) and
// a narrow instance (Y_OUT=8) share the same stimulus. Single-pair vectors
// come from a table; streaming, backpressure and reset use hand sequences.
module tb_idwt_synth_fir;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready;
  logic signed [6:0] a_in, d_in;
  logic signed [4:0] g0_0, g0_1, g0_2, g0_3, g1_0, g1_1, g1_2, g1_3;

  logic in_ready, out_valid, out_odd;
  logic signed [19:0] y_out;
  logic in_ready8, out_valid8, out_odd8;
  logic signed [7:0] y8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  idwt_synth_fir dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .d_in(d_in),
    .g0_0(g0_0), .g0_1(g0_1), .g0_2(g0_2), .g0_3(g0_3),
    .g1_0(g1_0), .g1_1(g1_1), .g1_2(g1_2), .g1_3(g1_3),
    .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out), .out_odd(out_odd)
  );

  idwt_synth_fir #(.Y_OUT(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .a_in(a_in), .d_in(d_in),
    .g0_0(g0_0), .g0_1(g0_1), .g0_2(g0_2), .g0_3(g0_3),
    .g1_0(g1_0), .g1_1(g1_1), .g1_2(g1_2), .g1_3(g1_3),
    .out_valid(out_valid8), .out_ready(out_ready), .y_out(y8), .out_odd(out_odd8)
  );

  typedef struct {
    string nm;
    int a, d;
    int g00, g01, g02, g03, g10, g11, g12, g13;
    int ye, yo;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input int a, input int d,
                     input int g00, input int g01, input int g02, input int g03,
                     input int g10, input int g11, input int g12, input int g13,
                     input int ye, input int yo);
    vec_t v;
    v.nm = nm; v.a = a; v.d = d;
    v.g00 = g00; v.g01 = g01; v.g02 = g02; v.g03 = g03;
    v.g10 = g10; v.g11 = g11; v.g12 = g12; v.g13 = g13;
    v.ye = ye; v.yo = yo;
    vecs.push_back(v);
  endtask

  // Expected value of an ACC_W sum after landing in an 8-bit output.
  function automatic int fit8(input int x);
`ifdef IDWT_SAT_EN
    if (x > 127) return 127;
    if (x < -128) return -128;
    return x;
`else
    int w;
    w = x & 255;
    if (w > 127) w = w - 256;
    return w;
`endif
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_taps(input int g00, input int g01, input int g02, input int g03,
                          input int g10, input int g11, input int g12, input int g13);
    g0_0 = 5'(g00); g0_1 = 5'(g01); g0_2 = 5'(g02); g0_3 = 5'(g03);
    g1_0 = 5'(g10); g1_1 = 5'(g11); g1_2 = 5'(g12); g1_3 = 5'(g13);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a_in = '0; d_in = '0;
    set_taps(0, 0, 0, 0, 0, 0, 0, 0);

    //   name        a    d   g0_0..g0_3       g1_0..g1_3       even   odd
    add("haar",      3,   1,  1, 1, 0, 0,      1, -1, 0, 0,       4,     2);
    add("haar_neg", -5,   7,  1, 1, 0, 0,      1, -1, 0, 0,       2,   -12);
    add("mixed",    10,  -3,  2, 3, 5, 7,     -1,  4, 6, -8,     23,    18);
    add("ext_pos", -64, -64, -16, 0, 0, 0,   -16,  0, 0, 0,    2048,     0);
    add("ext_neg",  63, -64, -16, 0, 0, 0,    15,  0, 0, 0,   -1968,     0);

    tick(); tick();
    rst = 1'b0;
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst y_out", int'(y_out), 0);
    chk("rst out_odd", int'(out_odd), 0);
    chk("rst in_ready", int'(in_ready), 1);

    // Single pair from reset, out_ready held high.
    foreach (vecs[i]) begin
      do_reset();
      set_taps(vecs[i].g00, vecs[i].g01, vecs[i].g02, vecs[i].g03,
               vecs[i].g10, vecs[i].g11, vecs[i].g12, vecs[i].g13);
      out_ready = 1'b1;
      a_in = 7'(vecs[i].a); d_in = 7'(vecs[i].d);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk($sformatf("%s ev valid", vecs[i].nm), int'(out_valid), 1);
      chk($sformatf("%s ev y", vecs[i].nm), int'(y_out), vecs[i].ye);
      chk($sformatf("%s ev odd", vecs[i].nm), int'(out_odd), 0);
      chk($sformatf("%s ev y8", vecs[i].nm), int'(y8), fit8(vecs[i].ye));
      tick();
      chk($sformatf("%s od y", vecs[i].nm), int'(y_out), vecs[i].yo);
      chk($sformatf("%s od odd", vecs[i].nm), int'(out_odd), 1);
      chk($sformatf("%s od y8", vecs[i].nm), int'(y8), fit8(vecs[i].yo));
      tick();
      chk($sformatf("%s idle valid", vecs[i].nm), int'(out_valid), 0);
    end

    // History taps, two pairs back to back: 0,0,5,5 with no idle cycle.
    do_reset();
    set_taps(0, 0, 1, 1, 0, 0, 0, 0);
    out_ready = 1'b1;
    a_in = 7'sd5; d_in = '0; in_valid = 1'b1;
    tick();
    chk("hist y0", int'(y_out), 0);
    chk("hist in_ready even", int'(in_ready), 0);
    a_in = -7'sd2;
    tick();
    chk("hist y1", int'(y_out), 0);
    chk("hist in_ready odd", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("hist y2 valid", int'(out_valid), 1);
    chk("hist y2", int'(y_out), 5);
    chk("hist y2 odd", int'(out_odd), 0);
    tick();
    chk("hist y3", int'(y_out), 5);
    chk("hist y3 odd", int'(out_odd), 1);
    tick();
    chk("hist done", int'(out_valid), 0);

    // Backpressure on both the even and the odd sample.
    do_reset();
    set_taps(1, 1, 0, 0, 1, -1, 0, 0);
    out_ready = 1'b0;
    a_in = 7'sd3; d_in = 7'sd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp even y c%0d", k), int'(y_out), 4);
      chk($sformatf("bp even valid c%0d", k), int'(out_valid), 1);
      chk($sformatf("bp even in_ready c%0d", k), int'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp odd y", int'(y_out), 2);
    chk("bp odd flag", int'(out_odd), 1);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("bp odd hold c%0d", k), int'(y_out), 2);
      chk($sformatf("bp odd in_ready c%0d", k), int'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp done", int'(out_valid), 0);

    // Reset in S_EVEN clears the output and the history; reset also beats
    // a simultaneous handshake in S_IDLE.
    do_reset();
    set_taps(0, 0, 1, 1, 0, 0, 1, 1);
    out_ready = 1'b0;
    a_in = 7'sd5; d_in = 7'sd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mid pre valid", int'(out_valid), 1);
    rst = 1'b1;
    tick();
    chk("mid rst valid", int'(out_valid), 0);
    chk("mid rst y", int'(y_out), 0);
    chk("mid rst odd", int'(out_odd), 0);
    chk("mid rst in_ready", int'(in_ready), 1);
    a_in = 7'sd7; d_in = 7'sd7; in_valid = 1'b1;
    tick();
    chk("rst beats accept", int'(out_valid), 0);
    rst = 1'b0;
    out_ready = 1'b1;
    a_in = 7'sd3; d_in = 7'sd1;
    tick();
    in_valid = 1'b0;
    chk("post rst even", int'(y_out), 0);
    tick();
    chk("post rst odd", int'(y_out), 0);
    a_in = '0; d_in = '0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("post rst hist even", int'(y_out), 4);
    tick();
    chk("post rst hist odd", int'(y_out), 4);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
